// File: rtl/network_source_arbiter_pkg.sv
// Shared definitions for the network_source arbiter and its round-robin picker.
package network_arbiter_config;

   // Default packet width. This value matches the processor's network input width.
   localparam int INP_WIDTH = 8;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_t;

   // Width of an owner id. A single requester still gets a one-bit id.
   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/network_source_arbiter_if.sv
// Requester-side and network_source-side handshake bundle for the arbiter.
interface network_source_arbiter_if
   import network_arbiter_config::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int PKT_WIDTH = INP_WIDTH,
   localparam int ID_WIDTH = id_width(NUM_REQ)
) ();

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_last;
   logic [PKT_WIDTH-1:0] req_pkt [NUM_REQ];
   logic [NUM_REQ-1:0]   req_ready;

   logic                 src_valid;
   logic [PKT_WIDTH-1:0] src;
   logic                 src_last;
   logic [ID_WIDTH-1:0]  src_id;
   logic                 src_ready;

   // The arbiter itself.
   modport master (
      input  req_valid, req_last, req_pkt, src_ready,
      output req_ready, src_valid, src, src_last, src_id
   );

   // The requesters and network_source around the arbiter.
   modport slave (
      output req_valid, req_last, req_pkt, src_ready,
      input  req_ready, src_valid, src, src_last, src_id
   );

endinterface

// File: rtl/network_source_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request after last_owner, with wrap.
module rr_pick
   import network_arbiter_config::*;
#(
   parameter int NUM_REQ   = 4,
   localparam int ID_WIDTH = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] last_owner,
   output logic [ID_WIDTH-1:0] pick,
   output logic                any
);

   // Scan from farthest to nearest so the nearest request after last_owner wins.
   always_comb begin
      int slot;
      logic [ID_WIDTH-1:0] idx;
      pick = '0;
      any  = 1'b0;
      slot = 0;
      idx  = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         slot = (int'(last_owner) + i) % NUM_REQ;
         idx  = ID_WIDTH'(slot);
         if (req[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/network_source_arbiter.sv
// Shares one network_source input among NUM_REQ requesters, one whole transaction at a time.
module network_source_arbiter
   import network_arbiter_config::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int PKT_WIDTH = INP_WIDTH,
   localparam int ID_WIDTH = id_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      arstn,
   network_source_arbiter_if.master  bus,
   output logic                      busy
);

   arb_state_t           state;
   logic [ID_WIDTH-1:0]  owner;
   logic [ID_WIDTH-1:0]  last_owner;
   logic [ID_WIDTH-1:0]  pick;
   logic                 any;
   logic                 accept;
   logic                 transfer;
   logic [NUM_REQ-1:0]   ready_vec;

   logic                 src_valid_q;
   logic [PKT_WIDTH-1:0] src_q;
   logic                 src_last_q;
   logic [ID_WIDTH-1:0]  src_id_q;

   rr_pick #(
      .NUM_REQ(NUM_REQ)
   ) u_rr_pick (
      .req        (bus.req_valid),
      .last_owner (last_owner),
      .pick       (pick),
      .any        (any)
   );

   // Only the owner may push, and only when the output register is free or draining.
   always_comb begin
      ready_vec = '0;
      accept    = (state == LOCKED) && (!src_valid_q || bus.src_ready);
      if (accept) begin
         ready_vec[owner] = 1'b1;
      end
      transfer = accept && bus.req_valid[owner];
   end

   // Grant FSM: arbitrate in IDLE, hold the grant until the owner's last packet.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= ID_WIDTH'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  owner <= pick;
                  state <= LOCKED;
               end
            end
            LOCKED: begin
               if (transfer && bus.req_last[owner]) begin
                  last_owner <= owner;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register: loads on transfer, empties on a pop with nothing new behind it.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         src_valid_q <= 1'b0;
         src_q       <= '0;
         src_last_q  <= 1'b0;
         src_id_q    <= '0;
      end else if (transfer) begin
         src_valid_q <= 1'b1;
         src_q       <= bus.req_pkt[owner];
         src_last_q  <= bus.req_last[owner];
         src_id_q    <= owner;
      end else if (src_valid_q && bus.src_ready) begin
         src_valid_q <= 1'b0;
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.src_valid = src_valid_q;
   assign bus.src       = src_q;
   assign bus.src_last  = src_last_q;
   assign bus.src_id    = src_id_q;
   assign busy          = (state == LOCKED);

endmodule

// File: tb/tb_network_source_arbiter.sv
// Scoreboard bench for network_source_arbiter: transaction-level round-robin model vs DUT output.
module tb_network_source_arbiter;
   import network_arbiter_config::*;

   localparam int NUM_REQ   = 4;
   localparam int PKT_WIDTH = 8;
   localparam int ID_WIDTH  = id_width(NUM_REQ);

   typedef struct packed {
      logic                 last;
      logic [PKT_WIDTH-1:0] pkt;
   } beat_t;

   typedef struct packed {
      logic [ID_WIDTH-1:0]  id;
      logic                 last;
      logic [PKT_WIDTH-1:0] pkt;
   } exp_t;

   logic clk = 1'b0;
   logic arstn;
   logic busy;

   beat_t stage_q [NUM_REQ][$];
   beat_t txq [NUM_REQ][$];
   exp_t  exp_q[$];
   int    out_cyc[$];
   int    cyc = 0;
   int    n_out = 0;
   int    tests = 0;
   int    fails = 0;
   logic [NUM_REQ-1:0] mid;
   int    stall_cnt [NUM_REQ];
   bit    gap_en;
   int    rdy_mode;
   int    bp_cnt;
   int    m_last;

   network_source_arbiter_if #(.NUM_REQ(NUM_REQ), .PKT_WIDTH(PKT_WIDTH)) bus ();

   network_source_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .PKT_WIDTH (PKT_WIDTH)
   ) dut (
      .clk   (clk),
      .arstn (arstn),
      .bus   (bus),
      .busy  (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used to measure spacing between output packets.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Queue one transaction of len packets for requester req; packets are first, first+step, ...
   task automatic addTxn(input int req, input int len, input logic [PKT_WIDTH-1:0] first,
                         input logic [PKT_WIDTH-1:0] step);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.pkt  = first + PKT_WIDTH'(k) * step;
         b.last = (k == len - 1);
         stage_q[req].push_back(b);
      end
   endtask

   // Reference model: serve whole transactions in round-robin order, then release them to the drivers.
   task automatic applyStimulus();
      beat_t work [NUM_REQ][$];
      beat_t b;
      exp_t  e;
      int    lo;
      int    sel;
      bit    found;
      lo = m_last;
      for (int i = 0; i < NUM_REQ; i++) work[i] = stage_q[i];
      forever begin
         found = 1'b0;
         sel   = 0;
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && work[(lo + k) % NUM_REQ].size() > 0) begin
               found = 1'b1;
               sel   = (lo + k) % NUM_REQ;
            end
         end
         if (!found) break;
         do begin
            b      = work[sel].pop_front();
            e.id   = ID_WIDTH'(sel);
            e.last = b.last;
            e.pkt  = b.pkt;
            exp_q.push_back(e);
         end while (!b.last);
         lo = sel;
      end
      m_last = lo;
      for (int i = 0; i < NUM_REQ; i++) begin
         foreach (stage_q[i][k]) txq[i].push_back(stage_q[i][k]);
         stage_q[i].delete();
      end
   endtask

   function automatic int pendingBeats();
      int s = 0;
      for (int i = 0; i < NUM_REQ; i++) s += txq[i].size();
      return s;
   endfunction

   task automatic waitDrain(input int budget, input string name);
      int w = 0;
      while ((exp_q.size() != 0 || pendingBeats() != 0) && w < budget) begin
         @(negedge clk);
         w++;
      end
      checkOutput(name, exp_q.size(), 0);
   endtask

   task automatic waitOut(input int target, input int budget, input string name);
      int w = 0;
      while (n_out < target && w < budget) begin
         @(negedge clk);
         w++;
      end
      checkOutput(name, 32'(n_out >= target), 1);
   endtask

   task automatic flushAll();
      for (int i = 0; i < NUM_REQ; i++) begin
         txq[i].delete();
         stage_q[i].delete();
         stall_cnt[i] = 0;
      end
      mid = '0;
      exp_q.delete();
      m_last = NUM_REQ - 1;
   endtask

   // Requester drivers and network_source ready: pop on handshake, present the next beat.
   initial begin
      logic [NUM_REQ-1:0] fired;
      beat_t b;
      bit nv;
      bus.req_valid = '0;
      bus.req_last  = '0;
      for (int i = 0; i < NUM_REQ; i++) bus.req_pkt[i] = '0;
      bus.src_ready = 1'b0;
      forever begin
         @(negedge clk);
         fired = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (fired[i] && txq[i].size() > 0) begin
               b      = txq[i].pop_front();
               mid[i] = !b.last;
            end
            if (txq[i].size() > 0) begin
               nv = 1'b1;
               if (mid[i] && stall_cnt[i] > 0) begin
                  nv = 1'b0;
                  stall_cnt[i]--;
               end else if (mid[i] && gap_en && $urandom_range(0, 3) == 0) begin
                  nv = 1'b0;
               end
               bus.req_valid[i] = nv;
               bus.req_last[i]  = txq[i][0].last;
               bus.req_pkt[i]   = txq[i][0].pkt;
            end else begin
               bus.req_valid[i] = 1'b0;
               bus.req_last[i]  = 1'b0;
            end
         end
         if (bp_cnt > 0) begin
            bus.src_ready = 1'b0;
            bp_cnt--;
         end else if (rdy_mode == 1) begin
            bus.src_ready = ($urandom_range(0, 9) < 7);
         end else begin
            bus.src_ready = 1'b1;
         end
      end
   end

   // Monitor: checks hold-under-backpressure, ready gating, and pops the scoreboard on each accept.
   initial begin
      bit                   stalled;
      logic [PKT_WIDTH-1:0] p_src;
      logic                 p_last;
      logic [ID_WIDTH-1:0]  p_id;
      exp_t                 e;
      stalled = 1'b0;
      p_src   = '0;
      p_last  = 1'b0;
      p_id    = '0;
      forever begin
         @(negedge clk);
         if (!arstn) begin
            stalled = 1'b0;
            continue;
         end
         if (stalled) begin
            checkOutput("hold", 32'({bus.src_valid, bus.src_last, bus.src_id, bus.src}),
                        32'({1'b1, p_last, p_id, p_src}));
         end
         if (bus.src_valid && !bus.src_ready) begin
            checkOutput("rdy_block", 32'(bus.req_ready), 0);
         end
         checkOutput("rdy_onehot", 32'($onehot0(bus.req_ready)), 1);
         if (bus.src_valid && bus.src_ready) begin
            n_out++;
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_pkt: got src=0x%0h id=%0d, expected no packet",
                        bus.src, bus.src_id);
            end else begin
               e = exp_q.pop_front();
               checkOutput("src", 32'(bus.src), 32'(e.pkt));
               checkOutput("src_last", 32'(bus.src_last), 32'(e.last));
               checkOutput("src_id", 32'(bus.src_id), 32'(e.id));
            end
         end
         stalled = bus.src_valid && !bus.src_ready;
         p_src   = bus.src;
         p_last  = bus.src_last;
         p_id    = bus.src_id;
      end
   end

   // Directed scenarios followed by randomized rounds.
   initial begin
      int start;
      int n0;
      arstn    = 1'b0;
      gap_en   = 1'b0;
      rdy_mode = 0;
      bp_cnt   = 0;
      flushAll();

      // Reset with everyone requesting, then 1-packet round robin 0,1,2,3,0,1.
      repeat (2) @(posedge clk);
      #2;
      addTxn(0, 1, 8'h40, 8'h00);
      addTxn(1, 1, 8'h50, 8'h00);
      addTxn(2, 1, 8'h60, 8'h00);
      addTxn(3, 1, 8'h70, 8'h00);
      addTxn(0, 1, 8'h41, 8'h00);
      addTxn(1, 1, 8'h51, 8'h00);
      applyStimulus();
      repeat (3) @(negedge clk);
      checkOutput("rst_req_valid", 32'(bus.req_valid), 32'hF);
      checkOutput("rst_src_valid", 32'(bus.src_valid), 0);
      checkOutput("rst_req_ready", 32'(bus.req_ready), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_src", 32'(bus.src), 0);
      checkOutput("rst_src_id", 32'(bus.src_id), 0);
      out_cyc.delete();
      arstn = 1'b1;
      waitDrain(100, "rr_drain");
      checkOutput("rr_count", out_cyc.size(), 6);
      for (int k = 1; k < out_cyc.size(); k++) begin
         checkOutput("rr_bubble", out_cyc[k] - out_cyc[k-1], 2);
      end

      // Requester 2 alone: 0x11,0x22,0x33 with exact latency and busy timing.
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2;
      addTxn(2, 3, 8'h11, 8'h11);
      applyStimulus();
      @(posedge clk);
      #2;
      checkOutput("t2_valid_rise", 32'(bus.req_valid[2]), 1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("t2_bubble", 32'(bus.src_valid), 0);
      checkOutput("t2_busy_on", 32'(busy), 1);
      @(negedge clk);
      checkOutput("t2_p1", 32'({bus.src_valid, bus.src_last, bus.src_id, bus.src}), 32'({1'b1, 1'b0, 2'd2, 8'h11}));
      @(negedge clk);
      checkOutput("t2_p2", 32'({bus.src_valid, bus.src_last, bus.src_id, bus.src}), 32'({1'b1, 1'b0, 2'd2, 8'h22}));
      checkOutput("t2_busy_mid", 32'(busy), 1);
      @(negedge clk);
      checkOutput("t2_p3", 32'({bus.src_valid, bus.src_last, bus.src_id, bus.src}), 32'({1'b1, 1'b1, 2'd2, 8'h33}));
      checkOutput("t2_busy_off", 32'(busy), 0);
      waitDrain(50, "t2_drain");

      // Backpressure for 5 cycles in the middle of a 6-packet transaction.
      @(posedge clk);
      #2;
      addTxn(0, 6, 8'h80, 8'h01);
      applyStimulus();
      start = n_out;
      waitOut(start + 2, 50, "bp_start");
      bp_cnt = 5;
      @(posedge clk);
      #2;
      n0 = n_out;
      repeat (5) @(negedge clk);
      checkOutput("bp_no_pop", n_out, n0);
      checkOutput("bp_src_valid", 32'(bus.src_valid), 1);
      waitDrain(100, "bp_drain");

      // Grant hold: owner 1 stalls 3 cycles mid-transaction while requester 3 waits.
      @(posedge clk);
      #2;
      addTxn(1, 4, 8'h90, 8'h01);
      addTxn(3, 2, 8'hA0, 8'h01);
      stall_cnt[1] = 3;
      applyStimulus();
      waitDrain(100, "hold_drain");

      // Reset in the middle of a 4-packet transaction, then restart from requester 0.
      @(posedge clk);
      #2;
      addTxn(1, 4, 8'hB0, 8'h01);
      applyStimulus();
      start = n_out;
      waitOut(start + 1, 50, "arst_start");
      @(posedge clk);
      #3;
      arstn = 1'b0;
      #1;
      checkOutput("arst_src_valid", 32'(bus.src_valid), 0);
      checkOutput("arst_busy", 32'(busy), 0);
      checkOutput("arst_req_ready", 32'(bus.req_ready), 0);
      flushAll();
      repeat (2) @(negedge clk);
      arstn = 1'b1;
      @(posedge clk);
      #2;
      addTxn(1, 4, 8'hC0, 8'h01);
      addTxn(0, 2, 8'hD0, 8'h01);
      applyStimulus();
      waitDrain(100, "arst_drain");

      // Randomized rounds with request gaps and random src_ready.
      gap_en   = 1'b1;
      rdy_mode = 1;
      for (int r = 0; r < 4; r++) begin
         @(posedge clk);
         #2;
         for (int i = 0; i < NUM_REQ; i++) begin
            for (int t = 0; t < int'($urandom_range(0, 2)); t++) begin
               addTxn(i, int'($urandom_range(1, 4)), PKT_WIDTH'($urandom), PKT_WIDTH'($urandom));
            end
         end
         applyStimulus();
         waitDrain(2000, "rand_drain");
      end

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/network_source_arbiter.md
Name: network_source_arbiter

Overview:
- Shares one network_source instruction stream among NUM_REQ independent requesters.
- Each requester presents a stream of packets terminated by a last flag. The arbiter grants one requester at a time in round-robin order and holds that grant until the requester's last packet.
- Output is a registered valid/ready stream that drives the src/src_valid/src_ready side of network_source, plus a sideband owner id so downstream logic can route sink output.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- PKT_WIDTH, processor_config::INP_WIDTH, packet width in bits.
- ID_WIDTH, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), owner id width (derived; do not override).

Ports:
- clk  input  1  system clock
- arstn  input  1  reset, asynchronous assert, active-low
- req_valid  input  NUM_REQ  per-requester packet valid
- req_last  input  NUM_REQ  per-requester: this packet ends the transaction
- req_pkt  input  NUM_REQ x PKT_WIDTH  per-requester packet, unpacked array
- req_ready  output  NUM_REQ  per-requester accept
- src_valid  output  1  packet valid toward network_source
- src  output  PKT_WIDTH  packet toward network_source
- src_last  output  1  registered copy of the owner's req_last
- src_id  output  ID_WIDTH  owner of the packet currently on src
- src_ready  input  1  network_source accept
- busy  output  1  high while in LOCKED state

Behaviour:
- Reset values: src_valid=0, src=0, src_last=0, src_id=0, req_ready=0, busy=0, state=IDLE, last_owner=NUM_REQ-1 (requester 0 wins first arbitration).
- States:
  - IDLE: compute the round-robin pick: first i with req_valid[i]=1, searching from (last_owner+1) mod NUM_REQ upward with wrap. If any request exists, set owner=pick and go to LOCKED next cycle. No packet is accepted in the arbitration cycle (1-cycle bubble). req_ready is all-zero in IDLE.
  - LOCKED: req_ready[owner] = (!src_valid || src_ready); all other req_ready bits are 0.
    - Transfer occurs when req_valid[owner] && req_ready[owner]. On transfer: src<=req_pkt[owner], src_last<=req_last[owner], src_id<=owner, src_valid<=1.
    - If the transferred packet has req_last=1: last_owner<=owner, go to IDLE.
- Output register:
  - If src_valid && src_ready and no transfer this cycle, src_valid<=0.
  - src, src_last and src_id hold while src_valid && !src_ready.
- Latency: 1 cycle from accepted request to src_valid. Sustained throughput of 1 packet/cycle within a transaction when src_ready=1.
- Fairness: a requester that loses arbitration wins within NUM_REQ-1 transactions.
- Boundary conditions:
  - A requester dropping req_valid mid-transaction does not release the grant; the arbiter stays LOCKED waiting for that requester.
  - A single-packet transaction (req_last=1 on the first packet) re-arbitrates immediately: IDLE the next cycle.
  - In IDLE, changes in req_valid only affect the current-cycle pick; no state beyond owner is captured.
  - The output register drains independently of state: a last packet may still sit in src while the arbiter is in IDLE or already LOCKED for the next owner.
  - Simultaneous src_ready pop and new transfer in the same cycle: the new packet loads and src_valid stays 1.
  - NUM_REQ=1: round robin degenerates to always granting requester 0, and src_id=0 always.
- Reset mid-transaction: all state clears asynchronously and any partial transaction is discarded. Requesters must restart their transaction from its first packet after reset.

Decomposition:
- Package network_arbiter_config: state enum typedef (IDLE, LOCKED) and the ID_WIDTH derivation function.
- One natural sub-module, rr_pick: a combinational round-robin priority encoder. Inputs are the request vector and last_owner; outputs are pick and any. It is reusable for a future sink-side router.

Test Plan:
- Reset: hold arstn=0 with all req_valid=1 -> src_valid=0, req_ready=0, busy=0. After release, the first grant goes to requester 0.
- Single requester 2 sends 3 packets (0x11, 0x22, 0x33, last on 0x33) with src_ready=1 -> src shows 0x11, 0x22, 0x33 on consecutive cycles starting 2 cycles after req_valid rises; src_id=2; src_last=1 only with 0x33; busy falls the cycle after 0x33 is accepted.
- All 4 requesters continuously valid, each sending 1-packet transactions -> src_id sequence 0,1,2,3,0,1, with one bubble cycle between packets.
- Backpressure: src_ready=0 for 5 cycles mid-transaction -> src and src_id stable, req_ready[owner]=0 while src_valid=1. Resumes with no lost or duplicated packets.
- Grant hold: owner 1 deasserts req_valid for 3 cycles mid-transaction while requester 3 is valid -> no packet from requester 3 appears until requester 1 sends its last packet.
- Reset asserted mid-transaction (second of 4 packets) -> src_valid=0 asynchronously. After release, arbitration restarts from requester 0 and no stale packet is emitted.
